mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, 32, data bus and register data width in bits.
REQ-002 Parameter ADDR_W, 32, address bus width in bits.
REQ-003 Parameter WAIT_CYCLES, 2, memory wait states per access; legal range 0..15.
REQ-004 One clock; reset is synchronous and active-high. Port clk, input, 1, rising-edge clock.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, request strobe, sampled only in IDLE.
REQ-007 Port Opcode, input, 4, operation: 4'b1101 LDR, 4'b1110 STR, others no-op.
REQ-008 Port Address, input, ADDR_W, memory address (source 1).
REQ-009 Port Data, input, DATA_W, store data (source 2).
REQ-010 Port busy, output, 1, high in every state except IDLE.
REQ-011 Port done, output, 1, one-cycle completion pulse.
REQ-012 Port LDRSel, output, 1, destination-register write select for a completed LDR.
REQ-013 Port LDRDataToDestReg, output, DATA_W, registered load data.
REQ-014 Port AddressBusSel, output, 1, bus-ownership flag.
REQ-015 Port AddressBus, output, ADDR_W, memory address.
REQ-016 Port RW, output, 1, 1 = write, 0 = read.
REQ-017 Port DataBus, inout, DATA_W, bidirectional memory data bus.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS and DONE.
- IDLE->ACCESS on start=1 with LDR/STR opcode; Opcode, Address and Data latched on that edge.
- ACCESS->DONE at access end.
- DONE->IDLE unconditionally.
REQ-019 In IDLE, start with any other opcode SHALL be ignored: no state change, no done pulse.
REQ-020 Without the macro, ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, using a 4-bit counter cleared on ACCESS entry.
REQ-021 ACCESS outputs SHALL be AddressBusSel=1 and AddressBus=latched address. RW=1 for STR, 0 for LDR.
REQ-022 DataBus SHALL be driven with latched Data only in ACCESS for STR; it SHALL be high-Z in all other states and for all other operations.
REQ-023 For LDR, DataBus SHALL be captured into LDRDataToDestReg on the last ACCESS edge; the register holds until the next LDR capture or reset.
REQ-024 In DONE, done=1; LDRSel=1 only if the operation is LDR; AddressBusSel=0 and RW=0.
REQ-025 Outside ACCESS, AddressBus SHALL be 0 and RW SHALL be 0.
REQ-026 start while busy=1 SHALL be ignored and not queued; a start in the DONE cycle is lost.
REQ-027 Total latency SHALL be WAIT_CYCLES+2 cycles from start acceptance to done; back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
REQ-028 Latched Address and Data SHALL be immune to input changes during busy.

Reset
REQ-029 rst=1 SHALL force IDLE from any state, including mid-ACCESS, and clear the counter.
REQ-030 Reset values: busy=0, done=0, LDRSel=0, LDRDataToDestReg=0, AddressBusSel=0, AddressBus=0, RW=0, DataBus high-Z.
REQ-031 rst SHALL take priority over start on the same edge.

Configuration
REQ-032 Macro MEMCTRL_READY_HANDSHAKE_EN, when defined, SHALL add port mem_ready, input, 1. With the macro, ACCESS ends on the first edge where mem_ready=1 (minimum 1 cycle, unbounded), WAIT_CYCLES is ignored, and LDR capture occurs on that edge. Without the macro, no mem_ready port exists and REQ-020 applies.

Verification
REQ-033 WAIT_CYCLES=2, start with LDR, Address=0x100, memory returns 0xDEADBEEF -> AddressBus=0x100 and RW=0 for 3 cycles; done and LDRSel pulse 4 cycles after start; LDRDataToDestReg=0xDEADBEEF.
REQ-034 STR, Address=0x200, Data=0x12345678 -> RW=1 and DataBus=0x12345678 for 3 cycles; done pulses with LDRSel=0; DataBus returns to Z.
REQ-035 start with Opcode=4'b0011 -> busy stays 0, no done pulse, DataBus stays Z.
REQ-036 rst asserted on the 2nd ACCESS cycle of a STR -> next cycle: IDLE, busy=0, AddressBusSel=0, DataBus Z, no done pulse.
REQ-037 Second start during busy, plus Address changed mid-access -> ignored; bus keeps the original address; exactly one done pulse.
REQ-038 With MEMCTRL_READY_HANDSHAKE_EN, mem_ready held low for 5 cycles then high on an LDR -> ACCESS lasts 6 cycles; data captured on the ready edge; done one cycle later.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: IDLE/ACCESS/DONE load-store controller driving a shared tristate data bus.
// Optional macro MEMCTRL_READY_HANDSHAKE_EN ends ACCESS on mem_ready instead of a wait counter.
`default_nettype none

module mem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        Opcode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data,
`ifdef MEMCTRL_READY_HANDSHAKE_EN
    input  logic              mem_ready,
`endif
    output logic              busy,
    output logic              done,
    output logic              LDRSel,
    output logic [DATA_W-1:0] LDRDataToDestReg,
    output logic              AddressBusSel,
    output logic [ADDR_W-1:0] AddressBus,
    output logic              RW,
    inout  wire  [DATA_W-1:0] DataBus
);

    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic              is_str;
    logic              drive_en;
    logic [DATA_W-1:0] data_q;
    logic              access_end;
    logic              op_valid;

    assign op_valid = (Opcode == OP_LDR) || (Opcode == OP_STR);

`ifdef MEMCTRL_READY_HANDSHAKE_EN
    assign access_end = mem_ready;
`else
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);
    logic [3:0] cnt;
    assign access_end = (cnt == LAST_CNT);
`endif

    // The bus is only ever driven by the latched store data, never by the live input.
    assign DataBus = drive_en ? data_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            is_str           <= 1'b0;
            drive_en         <= 1'b0;
            data_q           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            LDRSel           <= 1'b0;
            LDRDataToDestReg <= '0;
            AddressBusSel    <= 1'b0;
            AddressBus       <= '0;
            RW               <= 1'b0;
`ifndef MEMCTRL_READY_HANDSHAKE_EN
            cnt              <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    LDRSel <= 1'b0;
                    if (start && op_valid) begin
                        state         <= ACCESS;
                        is_str        <= (Opcode == OP_STR);
                        data_q        <= Data;
                        busy          <= 1'b1;
                        AddressBusSel <= 1'b1;
                        AddressBus    <= Address;
                        RW            <= (Opcode == OP_STR);
                        drive_en      <= (Opcode == OP_STR);
`ifndef MEMCTRL_READY_HANDSHAKE_EN
                        cnt           <= 4'd0;
`endif
                    end
                end
                ACCESS: begin
                    if (access_end) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        LDRSel        <= ~is_str;
                        AddressBusSel <= 1'b0;
                        AddressBus    <= '0;
                        RW            <= 1'b0;
                        drive_en      <= 1'b0;
                        if (!is_str) begin
                            LDRDataToDestReg <= DataBus;
                        end
                    end
`ifndef MEMCTRL_READY_HANDSHAKE_EN
                    else begin
                        cnt <= cnt + 4'd1;
                    end
`endif
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    LDRSel <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    LDRSel        <= 1'b0;
                    AddressBusSel <= 1'b0;
                    AddressBus    <= '0;
                    RW            <= 1'b0;
                    drive_en      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
